rx_counter_checker: RTL and testbench

- Receive-side end of the counter loopback link.
- Consumes 8-bit deserialized words from the HPIO RX data_to_fabric path, qualified by the RX FIFO read-valid.
- Finds the bit rotation at which the stream is a mod-256 incrementing counter (the pattern produced by counter_datagen), locks to it, and counts word errors.
- Status feeds the ILA and the lab pass/fail logic.

---
 rtl/rx_counter_checker.sv | 194 +++++++++++++++++++
 tb/tb_rx_counter_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_counter_checker.sv
// Receive-side counter checker: finds the bit rotation of an incrementing
// mod-256 stream, locks, counts word errors. Optional: CHECKER_ERR_CAPTURE_EN.
module rx_counter_checker #(
  parameter int DATA_W     = 8,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 data_valid,
  input  logic                 clr_counts,
  output logic                 locked,
  output logic [2:0]           bit_offset,
  output logic [DATA_W-1:0]    aligned_data,
  output logic                 aligned_valid,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [ERR_CNT_W-1:0] word_count,
`ifdef CHECKER_ERR_CAPTURE_EN
  output logic                 err_captured,
  output logic [DATA_W-1:0]    err_expected,
  output logic [DATA_W-1:0]    err_received,
`endif
  output logic                 lock_lost
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_N = 8'(LOSS_COUNT);

  state_e                 state_q;
  logic [DATA_W-1:0]      prev_raw_q;
  logic [DATA_W-1:0]      prev_al_q;
  logic [DATA_W-1:0]      expected_q;
  logic                   have_prev_q;
  logic [7:0]             match_cnt_q;
  logic [7:0]             err_run_q;
  logic [2:0]             bit_offset_q;
  logic                   locked_q;
  logic                   lock_lost_q;
  logic [DATA_W-1:0]      aligned_q;
  logic                   aligned_valid_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic [ERR_CNT_W-1:0]   word_cnt_q;

  logic [2*DATA_W-1:0]    pair;
  logic [DATA_W-1:0]      aligned_d;
  logic                   seq_ok;
  logic                   lock_ok;
  logic [7:0]             match_d;
  logic [7:0]             err_run_d;
  logic [ERR_CNT_W-1:0]   err_cnt_d;
  logic [ERR_CNT_W-1:0]   word_cnt_d;
  logic                   chk_word;
  logic                   err_hit;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(
    input logic [ERR_CNT_W-1:0] v
  );
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Offset 0 passes data_in straight through; higher offsets borrow
  // low bits of the previous raw word.
  always_comb begin
    pair      = {prev_raw_q, data_in};
    aligned_d = DATA_W'(pair >> bit_offset_q);
    seq_ok    = (aligned_d == prev_al_q + 8'd1);
    lock_ok   = (aligned_d == expected_q);
    match_d   = match_cnt_q + 8'd1;
    err_run_d = err_run_q + 8'd1;
    chk_word  = data_valid && (state_q == LOCKED);
    err_hit   = chk_word && !lock_ok;
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (clr_counts) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (chk_word) begin
      word_cnt_d = sat_inc(word_cnt_q);
      if (!lock_ok) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= SEARCH;
      prev_raw_q      <= '0;
      prev_al_q       <= '0;
      expected_q      <= '0;
      have_prev_q     <= 1'b0;
      match_cnt_q     <= '0;
      err_run_q       <= '0;
      bit_offset_q    <= '0;
      locked_q        <= 1'b0;
      lock_lost_q     <= 1'b0;
      aligned_q       <= '0;
      aligned_valid_q <= 1'b0;
      err_cnt_q       <= '0;
      word_cnt_q      <= '0;
    end else begin
      aligned_valid_q <= data_valid;
      lock_lost_q     <= 1'b0;
      err_cnt_q       <= err_cnt_d;
      word_cnt_q      <= word_cnt_d;
      if (data_valid) begin
        aligned_q  <= aligned_d;
        prev_raw_q <= data_in;
        unique case (state_q)
          SEARCH: begin
            if (!have_prev_q) begin
              prev_al_q   <= aligned_d;
              have_prev_q <= 1'b1;
            end else if (seq_ok) begin
              prev_al_q   <= aligned_d;
              match_cnt_q <= match_d;
              if (match_d == LOCK_N) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                expected_q <= aligned_d + 8'd1;
                err_run_q  <= '0;
              end
            end else begin
              bit_offset_q <= bit_offset_q + 3'd1;
              match_cnt_q  <= '0;
              have_prev_q  <= 1'b0;
            end
          end
          LOCKED: begin
            // Reference free-runs so one bad word costs one error.
            expected_q <= expected_q + 8'd1;
            if (lock_ok) begin
              err_run_q <= '0;
            end else begin
              err_run_q <= err_run_d;
              if (err_run_d == LOSS_N) begin
                state_q     <= SEARCH;
                locked_q    <= 1'b0;
                lock_lost_q <= 1'b1;
                match_cnt_q <= '0;
                have_prev_q <= 1'b0;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

`ifdef CHECKER_ERR_CAPTURE_EN
  logic              cap_q;
  logic [DATA_W-1:0] cap_exp_q;
  logic [DATA_W-1:0] cap_rcv_q;

  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      cap_q     <= 1'b0;
      cap_exp_q <= '0;
      cap_rcv_q <= '0;
    end else if (err_hit && !cap_q) begin
      cap_q     <= 1'b1;
      cap_exp_q <= expected_q;
      cap_rcv_q <= aligned_d;
    end
  end

  assign err_captured = cap_q;
  assign err_expected = cap_exp_q;
  assign err_received = cap_rcv_q;
`else
  logic unused_hit;
  assign unused_hit = err_hit;
`endif

  assign locked        = locked_q;
  assign bit_offset    = bit_offset_q;
  assign aligned_data  = aligned_q;
  assign aligned_valid = aligned_valid_q;
  assign error_count   = err_cnt_q;
  assign word_count    = word_cnt_q;
  assign lock_lost     = lock_lost_q;

endmodule

// File: tb/tb_rx_counter_checker.sv
// Scoreboard bench for rx_counter_checker: a word-level reference model
// predicts every output cycle; a monitor pops and compares.
module tb_rx_counter_checker;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int LOCK = 16;
  localparam int LOSS = 4;

  logic          clk;
  logic          rst;
  logic [7:0]    data_in;
  logic          data_valid;
  logic          clr_counts;
  logic          locked;
  logic [2:0]    bit_offset;
  logic [7:0]    aligned_data;
  logic          aligned_valid;
  logic [CW-1:0] error_count;
  logic [CW-1:0] word_count;
  logic          lock_lost;
`ifdef CHECKER_ERR_CAPTURE_EN
  logic          err_captured;
  logic [7:0]    err_expected;
  logic [7:0]    err_received;
`endif

  rx_counter_checker #(
    .DATA_W    (8),
    .LOCK_COUNT(LOCK),
    .LOSS_COUNT(LOSS),
    .ERR_CNT_W (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .clr_counts   (clr_counts),
    .locked       (locked),
    .bit_offset   (bit_offset),
    .aligned_data (aligned_data),
    .aligned_valid(aligned_valid),
    .error_count  (error_count),
    .word_count   (word_count),
`ifdef CHECKER_ERR_CAPTURE_EN
    .err_captured (err_captured),
    .err_expected (err_expected),
    .err_received (err_received),
`endif
    .lock_lost    (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit lk; int off; int ad; bit av;
    int ec; int wc; bit ll;
    bit cap; int ce; int cr;
  } exp_t;

  exp_t sbq[$];

  // Reference model state, in plain integers.
  bit m_lock, m_have, m_av, m_ll, m_cap;
  int m_off, m_praw, m_pal, m_match, m_exp, m_run;
  int m_ec, m_wc, m_ad, m_ce, m_cr;

  task automatic model_reset();
    m_lock = 0; m_have = 0; m_av = 0; m_ll = 0; m_cap = 0;
    m_off = 0; m_praw = 0; m_pal = 0; m_match = 0;
    m_exp = 0; m_run = 0; m_ec = 0; m_wc = 0; m_ad = 0;
    m_ce = 0; m_cr = 0;
  endtask

  task automatic model_step(bit r, bit v, int d, bit c);
    int al;
    m_ll = 0;
    m_av = v;
    if (r) begin
      model_reset();
      return;
    end
    if (v) begin
      al = ((m_praw * 256 + d) >> m_off) & 255;
      m_praw = d;
      m_ad = al;
      if (!m_lock) begin
        if (!m_have) begin
          m_pal = al; m_have = 1;
        end else if (al == ((m_pal + 1) & 255)) begin
          m_pal = al; m_match++;
          if (m_match == LOCK) begin
            m_lock = 1; m_exp = (al + 1) & 255; m_run = 0;
          end
        end else begin
          m_off = (m_off + 1) % 8; m_match = 0; m_have = 0;
        end
      end else begin
        if (m_wc < MAXC) m_wc++;
        if (al == m_exp) m_run = 0;
        else begin
          if (m_ec < MAXC) m_ec++;
          m_run++;
          if (!m_cap) begin
            m_cap = 1; m_ce = m_exp; m_cr = al;
          end
        end
        m_exp = (m_exp + 1) & 255;
        if (m_run == LOSS) begin
          m_lock = 0; m_ll = 1; m_match = 0; m_have = 0;
        end
      end
    end
    if (c) begin
      m_ec = 0; m_wc = 0; m_cap = 0; m_ce = 0; m_cr = 0;
    end
  endtask

  task automatic drive(bit r, bit v, int d, bit c);
    exp_t e;
    @(negedge clk);
    rst = r; data_valid = v; data_in = 8'(d); clr_counts = c;
    model_step(r, v, d, c);
    e.lk = m_lock; e.off = m_off; e.ad = m_ad; e.av = m_av;
    e.ec = m_ec; e.wc = m_wc; e.ll = m_ll;
    e.cap = m_cap; e.ce = m_ce; e.cr = m_cr;
    sbq.push_back(e);
  endtask

  // Counter source: word n of the stream at generator rotation goff.
  int cnt;
  int goff;

  task automatic word(bit v, bit corrupt, int cv, bit c);
    int cn, cn1, raw;
    cn  = corrupt ? (cv & 255) : (cnt & 255);
    cn1 = (cnt + 1) & 255;
    if (goff == 0) raw = cn;
    else raw = (((cn << 8) | cn1) >> (8 - goff)) & 255;
    if (!v) raw = int'($urandom_range(0, 255));
    drive(1'b0, v, raw, c);
    if (v) cnt++;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  exp_t me;
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("locked", int'(locked), int'(me.lk));
      chk("bit_offset", int'(bit_offset), me.off);
      chk("aligned_data", int'(aligned_data), me.ad);
      chk("aligned_valid", int'(aligned_valid), int'(me.av));
      chk("error_count", int'(error_count), me.ec);
      chk("word_count", int'(word_count), me.wc);
      chk("lock_lost", int'(lock_lost), int'(me.ll));
`ifdef CHECKER_ERR_CAPTURE_EN
      chk("err_captured", int'(err_captured), int'(me.cap));
      chk("err_expected", int'(err_expected), me.ce);
      chk("err_received", int'(err_received), me.cr);
`endif
    end
  end

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0; clr_counts = 1'b0;
    model_reset();
    repeat (3) drive(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("reset_locked", int'(locked), 0);
    chk("reset_wc", int'(word_count), 0);

    // Clean stream at offset 0: lock on the 17th word.
    cnt = 0; goff = 0;
    repeat (16) word(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("pre_lock", int'(locked), 0);
    word(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("lock17", int'(locked), 1);
    chk("lock17_off", int'(bit_offset), 0);
    repeat (10) word(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("wc_after10", int'(word_count), 10);
    chk("ec_clean", int'(error_count), 0);

    // Stream rotated to offset 5, crossing 0xFF->0x00 while locked.
    drive(1'b1, 1'b0, 0, 1'b0);
    cnt = 224; goff = 5;
    repeat (60) word(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("off5_locked", int'(locked), 1);
    chk("off5_offset", int'(bit_offset), 5);
    chk("off5_ec", int'(error_count), 0);

    // Single corrupted word 0x42 -> 0x99.
    drive(1'b1, 1'b0, 0, 1'b0);
    cnt = 'h20; goff = 0;
    while (cnt != 'h42) word(1'b1, 1'b0, 0, 1'b0);
    word(1'b1, 1'b1, 'h99, 1'b0);
    settle();
    chk("one_err_ec", int'(error_count), 1);
    chk("one_err_lk", int'(locked), 1);
`ifdef CHECKER_ERR_CAPTURE_EN
    chk("cap_flag", int'(err_captured), 1);
    chk("cap_exp", int'(err_expected), 'h42);
    chk("cap_rcv", int'(err_received), 'h99);
`endif
    word(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("after_43_ec", int'(error_count), 1);

    // Four consecutive bad words force re-search.
    repeat (3) word(1'b1, 1'b1, cnt ^ 'h5A, 1'b0);
    settle();
    chk("three_bad_lk", int'(locked), 1);
    word(1'b1, 1'b1, cnt ^ 'h5A, 1'b0);
    settle();
    chk("loss_pulse", int'(lock_lost), 1);
    chk("loss_lk", int'(locked), 0);
    chk("loss_ec", int'(error_count), 5);
    repeat (17) word(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("relock", int'(locked), 1);
    chk("relock_off", int'(bit_offset), 0);

    // Valid 1-of-3 during lock.
    for (int i = 0; i < 60; i++) word(i % 3 == 0, 1'b0, 0, 1'b0);
    settle();
    chk("gap_ec", int'(error_count), 5);

    // clr_counts in the same cycle as an error.
    word(1'b1, 1'b1, cnt ^ 'h33, 1'b1);
    settle();
    chk("clr_ec", int'(error_count), 0);
    chk("clr_wc", int'(word_count), 0);
    chk("clr_lk", int'(locked), 1);

    // Saturation of word_count.
    repeat (300) word(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("wc_sat", int'(word_count), MAXC);

    // Randomized traffic with errors, gaps, clears and re-alignments.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        drive(1'b1, 1'b0, 0, 1'b0);
        goff = int'($urandom_range(0, 7));
      end else begin
        word($urandom_range(0, 3) != 0,
             $urandom_range(0, 19) == 0,
             int'($urandom_range(0, 255)),
             $urandom_range(0, 99) == 0);
      end
    end

    // Reset in the middle of lock.
    drive(1'b1, 1'b0, 0, 1'b0);
    cnt = 0; goff = 0;
    repeat (25) word(1'b1, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b1, cnt & 255, 1'b0);
    settle();
    chk("rst_lk", int'(locked), 0);
    chk("rst_wc", int'(word_count), 0);
    chk("rst_av", int'(aligned_valid), 0);
    chk("rst_ad", int'(aligned_data), 0);

    drive(1'b0, 1'b0, 0, 1'b0);
    settle();
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
